mont_conversion: RTL and testbench

//   Converts a natural residue into Montgomery form: x_mont = (x_in * R) mod N, with R = 2**WIDTH.

---
 rtl/mont_pkg.sv | 12 +
 rtl/mont_mod_step.sv | 26 ++
 rtl/mont_conversion.sv | 81 ++++++++
 tb/tb_mont_conversion.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath blocks (conversion, reduction, multiplier).
package mont_pkg;

  localparam int unsigned DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/mont_mod_step.sv
// One serial modular step: r_next = (2r + b) mod N, assuming r < N on entry.
module mont_mod_step #(
  parameter int unsigned WIDTH = 512
) (
  input  logic [WIDTH:0]   r,
  input  logic             b,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] n_ext;

  assign t     = {r, b};
  assign n_ext = {2'b00, N};

  // r < N keeps t < 2N, so a single conditional subtract lands back in range.
  always_comb begin
    r_next = '0;
    if (N != '0) begin
      if (t >= n_ext) r_next = (WIDTH+1)'(t - n_ext);
      else            r_next = (WIDTH+1)'(t);
    end
  end

endmodule

// File: rtl/mont_conversion.sv
// Serial conversion of x_in into Montgomery form: x_mont = (x_in * 2**WIDTH) mod N.
module mont_conversion
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] N,
  input  logic             valid_in,
  output logic [WIDTH-1:0] x_mont,
  output logic             valid_out,
  output logic             busy_out
);

  localparam int unsigned     CNT_W     = $clog2(2*WIDTH+1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2*WIDTH-1);

  conv_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] n_reg;

  // The operand shifts out MSB first; zero fill supplies the trailing WIDTH zero bits.
  mont_mod_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .b      (x_sh[WIDTH-1]),
    .N      (n_reg),
    .r_next (r_next)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      x_sh      <= '0;
      n_reg     <= '0;
      x_mont    <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            x_sh     <= x_in;
            n_reg    <= N;
            r        <= '0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          r    <= r_next;
          x_sh <= {x_sh[WIDTH-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            x_mont    <= r_next[WIDTH-1:0];
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_conversion.sv
// Self-checking bench for mont_conversion at WIDTH=16 and WIDTH=512 against arithmetic reference models.
module tb_mont_conversion;

  localparam logic [15:0] N16 = 16'd33227;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [15:0]  x16 = '0, n16 = '0, xm16;
  logic         v16 = 1'b0, vo16, b16;
  logic [511:0] x512 = '0, n512 = '0, xm512;
  logic         v512 = 1'b0, vo512, b512;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mont_conversion #(.WIDTH(16)) dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .x_in(x16), .N(n16), .valid_in(v16),
    .x_mont(xm16), .valid_out(vo16), .busy_out(b16)
  );

  mont_conversion #(.WIDTH(512)) dut512 (
    .clk_in(clk), .rst_n_in(rst_n), .x_in(x512), .N(n512), .valid_in(v512),
    .x_mont(xm512), .valid_out(vo512), .busy_out(b512)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // (x * 2**w) mod n by plain wide arithmetic; n == 0 is defined as 0.
  function automatic logic [511:0] ref_mont(input logic [511:0] x, input logic [511:0] n, input int w);
    logic [1023:0] t;
    if (n == '0) return '0;
    t = {512'd0, x} << w;
    return 512'(t % {512'd0, n});
  endfunction

  // Montgomery reduction xm * R^-1 mod n with R = 2**512, n odd.
  function automatic logic [511:0] redc(input logic [511:0] xm, input logic [511:0] n);
    logic [511:0]  inv, np, m;
    logic [1025:0] s, u;
    inv = n;
    for (int i = 0; i < 9; i++) inv = inv * (512'd2 - n * inv);
    np = -inv;
    m  = xm * np;
    s  = {514'd0, xm} + {514'd0, m} * {514'd0, n};
    u  = s >> 512;
    if (u >= {514'd0, n}) u = u - {514'd0, n};
    return u[511:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run16(input logic [15:0] x, input logic [15:0] n, input string tag);
    int edges;
    @(posedge clk); #1;
    x16 = x; n16 = n; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; x16 = 16'($urandom); n16 = 16'($urandom);
    edges = 0;
    while (vo16 !== 1'b1 && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, "_latency"}, 512'(edges), 512'd32);
    check({tag, "_result"}, 512'(xm16), ref_mont(512'(x), 512'(n), 16));
    check({tag, "_busy_done"}, 512'(b16), 512'd1);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 512'(vo16), 512'd0);
    check({tag, "_busy_drop"}, 512'(b16), 512'd0);
  endtask

  task automatic run512(input logic [511:0] x, input logic [511:0] n, input string tag);
    int edges;
    @(posedge clk); #1;
    x512 = x; n512 = n; v512 = 1'b1;
    @(posedge clk); #1;
    v512 = 1'b0; x512 = rand512(); n512 = rand512();
    edges = 0;
    while (vo512 !== 1'b1 && edges < 1100) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, "_latency"}, 512'(edges), 512'd1024);
    check({tag, "_result"}, xm512, ref_mont(x, n, 512));
    check({tag, "_roundtrip"}, redc(xm512, n), x);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 512'(vo512), 512'd0);
  endtask

  initial begin
    logic [15:0]  rx, rn;
    logic [511:0] bx, bn;
    int edges, pulses;

    // Reset values before any clock edge
    #1;
    check("rst_xm16", 512'(xm16), 512'd0);
    check("rst_vo16", 512'(vo16), 512'd0);
    check("rst_b16", 512'(b16), 512'd0);
    check("rst_xm512", xm512, 512'd0);
    check("rst_vo512", 512'(vo512), 512'd0);
    check("rst_b512", 512'(b512), 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed values and boundaries
    run16(16'd46, N16, "basic46");
    check("basic46_const", 512'(xm16), 512'd24226);
    run16(16'd0, N16, "x0");
    run16(16'd1, N16, "x1");
    check("x1_const", 512'(xm16), 512'd32309);
    run16(16'd65535, N16, "xmax");
    check("xmax_const", 512'(xm16), 512'd12967);
    run16(16'd46, 16'd1, "n1");
    run16(16'd12345, 16'd0, "n0");

    // Random operands, fixed and random moduli
    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom);
      rn = (i < 3) ? N16 : 16'($urandom);
      run16(rx, rn, "rand16");
    end

    // Request while busy is ignored
    @(posedge clk); #1;
    x16 = 16'd46; n16 = N16; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    edges = 0; pulses = 0;
    repeat (10) begin @(posedge clk); #1; edges++; end
    x16 = 16'd1; v16 = 1'b1;
    @(posedge clk); #1; edges++;
    v16 = 1'b0;
    while (vo16 !== 1'b1 && edges < 50) begin @(posedge clk); #1; edges++; end
    check("busy_ign_latency", 512'(edges), 512'd32);
    check("busy_ign_result", 512'(xm16), 512'd24226);
    repeat (40) begin
      if (vo16 === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check("busy_ign_pulses", 512'(pulses), 512'd1);

    // Abort by reset mid-SHIFT
    @(posedge clk); #1;
    x16 = 16'd46; n16 = N16; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_xm", 512'(xm16), 512'd0);
    check("abort_vo", 512'(vo16), 512'd0);
    check("abort_busy", 512'(b16), 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vo16 === 1'b1) pulses++;
    end
    check("abort_no_valid", 512'(pulses), 512'd0);
    run16(16'd1, N16, "after_abort");
    check("after_abort_const", 512'(xm16), 512'd32309);

    // WIDTH=512 round trip and back-to-back requests
    for (int i = 0; i < 3; i++) begin
      bn = rand512();
      bn[511] = 1'b1;
      bn[0] = 1'b1;
      bx = rand512() % bn;
      run512(bx, bn, (i == 0) ? "rt512" : "b2b512");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
